// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALUOp encodings, control widths
// and the packed ID/EX control bundle with its bubble value.
package mips_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;

    // Control carried from ID to EX; valid travels with the control so a
    // bubble clears both in one place.
    typedef struct packed {
        logic            valid;
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic            regdst;
        logic [1:0]      aluop;
        logic            alusrc;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An invalid decode slot must not carry any write enables into EX.
    function automatic ctrl_t ctrl_gate(input ctrl_t c);
        return c.valid ? c : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous clear, flush-to-zero, hold enable.
module pipe_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Priority: reset, then flush, then hold, otherwise capture d.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (flush) begin
            q_q <= '0;
        end else if (!hold) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath, with stall, flush,
// valid tracking and a count of valid instructions issued into EX.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [M_W-1:0]    id_m,
    input  logic              id_regdst,
    input  logic [1:0]        id_aluop,
    input  logic              id_alusrc,
    input  logic [DATA_W-1:0] id_npc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    output logic              ex_valid,
    output logic [WB_W-1:0]   ex_wb,
    output logic [M_W-1:0]    ex_m,
    output logic              ex_regdst,
    output logic [1:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_npc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CNT_W-1:0]  issue_count
);

    localparam int unsigned DBUS_W = 4 * DATA_W + 10;

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic [CTRL_W-1:0] ex_ctrl_bits;
    logic [DBUS_W-1:0] id_data;
    logic [DBUS_W-1:0] ex_data;
    logic [CNT_W-1:0]  issue_count_q;

    // Assemble the control bundle, zeroed when the decode slot is empty.
    always_comb begin
        id_ctrl        = CTRL_BUBBLE;
        id_ctrl.valid  = id_valid;
        id_ctrl.wb     = id_wb;
        id_ctrl.m      = id_m;
        id_ctrl.regdst = id_regdst;
        id_ctrl.aluop  = id_aluop;
        id_ctrl.alusrc = id_alusrc;
        id_ctrl        = ctrl_gate(id_ctrl);
    end

    assign id_data = {id_npc, id_rd1, id_rd2, id_imm, id_rt, id_rd};

    pipe_reg #(
        .WIDTH(CTRL_W)
    ) u_ctrl_reg (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .hold (stall),
        .d    (id_ctrl),
        .q    (ex_ctrl_bits)
    );

    pipe_reg #(
        .WIDTH(DBUS_W)
    ) u_data_reg (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .hold (stall),
        .d    (id_data),
        .q    (ex_data)
    );

    assign ex_ctrl = ctrl_t'(ex_ctrl_bits);

    // Count valid loads; flush and stall both leave the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count_q <= '0;
        end else if (!flush && !stall && id_valid) begin
            issue_count_q <= issue_count_q + CNT_W'(1);
        end
    end

    // Unpack registered bundles onto the EX-side ports.
    always_comb begin
        ex_valid  = ex_ctrl.valid;
        ex_wb     = ex_ctrl.wb;
        ex_m      = ex_ctrl.m;
        ex_regdst = ex_ctrl.regdst;
        ex_aluop  = ex_ctrl.aluop;
        ex_alusrc = ex_ctrl.alusrc;
        {ex_npc, ex_rd1, ex_rd2, ex_imm, ex_rt, ex_rd} = ex_data;
        // funct is a slice of the stored immediate, never its own flop.
        ex_funct    = ex_imm[5:0];
        issue_count = issue_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (default widths plus CNT_W=4).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic        id_regdst;
    logic [1:0]  id_aluop;
    logic        id_alusrc;
    logic [31:0] id_npc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rt, id_rd;

    logic        ex_valid;
    logic [1:0]  ex_wb;
    logic [2:0]  ex_m;
    logic        ex_regdst;
    logic [1:0]  ex_aluop;
    logic        ex_alusrc;
    logic [5:0]  ex_funct;
    logic [31:0] ex_npc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rt, ex_rd;
    logic [15:0] issue_count;

    logic        s_valid;
    logic [1:0]  s_wb;
    logic [2:0]  s_m;
    logic        s_regdst;
    logic [1:0]  s_aluop;
    logic        s_alusrc;
    logic [5:0]  s_funct;
    logic [31:0] s_npc, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rt, s_rd;
    logic [3:0]  s_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_wb(id_wb), .id_m(id_m), .id_regdst(id_regdst), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_npc(id_npc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_m(ex_m), .ex_regdst(ex_regdst),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_funct(ex_funct),
        .ex_npc(ex_npc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .issue_count(issue_count)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_wb(id_wb), .id_m(id_m), .id_regdst(id_regdst), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_npc(id_npc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(s_valid), .ex_wb(s_wb), .ex_m(s_m), .ex_regdst(s_regdst),
        .ex_aluop(s_aluop), .ex_alusrc(s_alusrc), .ex_funct(s_funct),
        .ex_npc(s_npc), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rt(s_rt), .ex_rd(s_rd), .issue_count(s_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 64'(ex_valid), 64'd0);
        check({tag, ".wb"}, 64'(ex_wb), 64'd0);
        check({tag, ".m"}, 64'(ex_m), 64'd0);
        check({tag, ".regdst"}, 64'(ex_regdst), 64'd0);
        check({tag, ".aluop"}, 64'(ex_aluop), 64'd0);
        check({tag, ".alusrc"}, 64'(ex_alusrc), 64'd0);
        check({tag, ".funct"}, 64'(ex_funct), 64'd0);
        check({tag, ".npc"}, 64'(ex_npc), 64'd0);
        check({tag, ".rd1"}, 64'(ex_rd1), 64'd0);
        check({tag, ".rd2"}, 64'(ex_rd2), 64'd0);
        check({tag, ".imm"}, 64'(ex_imm), 64'd0);
        check({tag, ".rt"}, 64'(ex_rt), 64'd0);
        check({tag, ".rd"}, 64'(ex_rd), 64'd0);
        check({tag, ".count"}, 64'(issue_count), 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_wb = 2'b00; id_m = 3'b000; id_regdst = 1'b0; id_aluop = 2'b00;
        id_alusrc = 1'b0; id_npc = 32'h0; id_rd1 = 32'h0; id_rd2 = 32'h0;
        id_imm = 32'h0; id_rt = 5'd0; id_rd = 5'd0;

        // Reset state.
        tick();
        check_all_zero("reset");
        check("reset.count4", 64'(s_count), 64'd0);

        // R-type add.
        rst = 1'b0; id_valid = 1'b1; id_aluop = 2'b10; id_imm = 32'h0000_0020;
        id_wb = 2'b10; id_m = 3'b000; id_regdst = 1'b1; id_alusrc = 1'b0;
        id_npc = 32'h0000_0104; id_rd1 = 32'h5; id_rd2 = 32'h7; id_rt = 5'd2; id_rd = 5'd3;
        tick();
        check("add.aluop", 64'(ex_aluop), 64'h2);
        check("add.funct", 64'(ex_funct), 64'h20);
        check("add.wb", 64'(ex_wb), 64'h2);
        check("add.valid", 64'(ex_valid), 64'h1);
        check("add.count", 64'(issue_count), 64'd1);
        check("add.regdst", 64'(ex_regdst), 64'h1);
        check("add.npc", 64'(ex_npc), 64'h104);
        check("add.rd2", 64'(ex_rd2), 64'h7);
        check("add.rt", 64'(ex_rt), 64'd2);
        check("add.rd", 64'(ex_rd), 64'd3);

        // Stall three cycles while inputs change.
        stall = 1'b1; id_imm = 32'h0000_002A; id_aluop = 2'b01; id_wb = 2'b01;
        id_rd1 = 32'h99; id_alusrc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.funct", 64'(ex_funct), 64'h20);
            check("stall.aluop", 64'(ex_aluop), 64'h2);
            check("stall.rd1", 64'(ex_rd1), 64'h5);
            check("stall.count", 64'(issue_count), 64'd1);
        end

        // Release captures the inputs present now.
        stall = 1'b0;
        tick();
        check("release.funct", 64'(ex_funct), 64'h2A);
        check("release.aluop", 64'(ex_aluop), 64'h1);
        check("release.alusrc", 64'(ex_alusrc), 64'h1);
        check("release.rd1", 64'(ex_rd1), 64'h99);
        check("release.count", 64'(issue_count), 64'd2);

        // Flush beats stall.
        flush = 1'b1; stall = 1'b1; id_m = 3'b010;
        tick();
        check("flush.valid", 64'(ex_valid), 64'd0);
        check("flush.m", 64'(ex_m), 64'd0);
        check("flush.aluop", 64'(ex_aluop), 64'd0);
        check("flush.funct", 64'(ex_funct), 64'd0);
        check("flush.wb", 64'(ex_wb), 64'd0);
        check("flush.rd1", 64'(ex_rd1), 64'd0);
        check("flush.count", 64'(issue_count), 64'd2);

        // Invalid lw: control zeroed, data loaded.
        flush = 1'b0; stall = 1'b0; id_valid = 1'b0; id_wb = 2'b11; id_m = 3'b010;
        id_aluop = 2'b00; id_alusrc = 1'b1; id_rd1 = 32'h0000_1234; id_imm = 32'h0000_0008;
        tick();
        check("inv.wb", 64'(ex_wb), 64'd0);
        check("inv.m", 64'(ex_m), 64'd0);
        check("inv.alusrc", 64'(ex_alusrc), 64'd0);
        check("inv.valid", 64'(ex_valid), 64'd0);
        check("inv.rd1", 64'(ex_rd1), 64'h1234);
        check("inv.funct", 64'(ex_funct), 64'h08);
        check("inv.count", 64'(issue_count), 64'd2);

        // Counter wrap on the CNT_W=4 instance.
        rst = 1'b1;
        tick();
        check("wrap.rst4", 64'(s_count), 64'd0);
        rst = 1'b0; id_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            id_imm = 32'(i);
            tick();
            check("wrap.count4", 64'(s_count), 64'(i % 16));
            check("wrap.count16", 64'(issue_count), 64'(i));
            check("wrap.funct4", 64'(s_funct), 64'(i));
        end

        // Reset during a stall with loaded state.
        rst = 1'b1;
        tick();
        rst = 1'b0; id_valid = 1'b1; id_wb = 2'b10; id_aluop = 2'b10; id_imm = 32'h25;
        id_npc = 32'h200; id_rd1 = 32'h11; id_rd2 = 32'h22; id_rt = 5'd7; id_rd = 5'd9;
        tick();
        check("pre.count", 64'(issue_count), 64'd1);
        check("pre.funct", 64'(ex_funct), 64'h25);
        stall = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("rststall");
        rst = 1'b0; stall = 1'b0;
        tick();
        check("post.count", 64'(issue_count), 64'd1);
        check("post.valid", 64'(ex_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
